// File: rtl/vga_pixel_fifo.sv
// Elastic pixel buffer feeding VGA scan-out, with start-of-frame alignment and black substitution on underrun.
// Optional underflow statistics counter enabled by defining VGA_PIXEL_FIFO_STATS_EN.
module vga_pixel_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PIXEL_WIDTH = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           write_valid,
  output logic                           write_ready,
  input  logic [PIXEL_WIDTH-1:0]         write_pixel,
  input  logic                           write_frame_start,
  input  logic                           frame_begin,
  input  logic                           read_enable,
  output logic [PIXEL_WIDTH-1:0]         read_pixel,
  output logic                           underflow,
  output logic                           resync,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic [15:0]                    underflow_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned EW = PIXEL_WIDTH + 1;

  typedef enum logic [1:0] {
    S_SEEK   = 2'd0,
    S_ARMED  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  logic [EW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_write_ready;
  logic [PIXEL_WIDTH-1:0] r_read_pixel;
  logic                   r_underflow;
  logic                   r_resync;
  state_t                 r_state;

  state_t                 w_state_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic [EW-1:0]          w_head;
  logic                   w_next_tag;
  logic                   w_aligned;
  logic [LW-1:0]          w_level_nxt;
  logic [PIXEL_WIDTH-1:0] w_pixel_nxt;
  logic                   w_underflow_nxt;
  logic                   w_resync_nxt;

  assign w_push      = write_valid && r_write_ready;
  assign w_empty     = (r_level == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_next_tag  = r_mem[r_rd_ptr + AW'(1)][EW-1];
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // Frame alignment looks at whichever entry is at the head once this cycle's pop is done
  assign w_aligned = w_pop ? ((r_level > LW'(1)) && w_next_tag)
                           : (!w_empty && w_head[EW-1]);

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_pixel_nxt     = r_read_pixel;
    w_underflow_nxt = 1'b0;
    w_resync_nxt    = 1'b0;
    case (r_state)
      S_SEEK: begin
        w_pixel_nxt = '0;
        if (!w_empty) begin
          if (w_head[EW-1]) w_state_nxt = S_ARMED;
          else              w_pop       = 1'b1;
        end
      end
      S_ARMED: begin
        w_pixel_nxt = '0;
        if (frame_begin) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (read_enable) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_pixel_nxt = w_head[PIXEL_WIDTH-1:0];
          end else begin
            w_pixel_nxt     = '0;
            w_underflow_nxt = 1'b1;
            w_state_nxt     = S_SEEK;
          end
        end
        if (frame_begin && !w_underflow_nxt && !w_aligned) begin
          w_resync_nxt = 1'b1;
          w_pixel_nxt  = '0;
          w_state_nxt  = S_SEEK;
        end
      end
      default: begin
        w_pixel_nxt = '0;
        w_state_nxt = S_SEEK;
      end
    endcase
  end

  // Storage array carries no reset; only pointers and level define validity
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {write_frame_start, write_pixel};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_SEEK;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_write_ready <= 1'b1;
      r_read_pixel  <= '0;
      r_underflow   <= 1'b0;
      r_resync      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_level       <= w_level_nxt;
      r_write_ready <= (w_level_nxt != LW'(DEPTH));
      r_read_pixel  <= w_pixel_nxt;
      r_underflow   <= w_underflow_nxt;
      r_resync      <= w_resync_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

`ifdef VGA_PIXEL_FIFO_STATS_EN
  logic [15:0] r_underflow_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow_count <= '0;
    end else if (w_underflow_nxt && (r_underflow_count != 16'hFFFF)) begin
      r_underflow_count <= r_underflow_count + 16'd1;
    end
  end

  assign underflow_count = r_underflow_count;
`else
  assign underflow_count = 16'h0000;
`endif

  assign write_ready = r_write_ready;
  assign read_pixel  = r_read_pixel;
  assign underflow   = r_underflow;
  assign resync      = r_resync;
  assign level       = r_level;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo with a pixel scoreboard checked as scan-out pops.
module tb_vga_pixel_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 3;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_valid = 1'b0;
  logic          write_ready;
  logic [PW-1:0] write_pixel = '0;
  logic          write_frame_start = 1'b0;
  logic          frame_begin = 1'b0;
  logic          read_enable = 1'b0;
  logic [PW-1:0] read_pixel;
  logic          underflow;
  logic          resync;
  logic [LW-1:0] level;
  logic [15:0]   underflow_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q [$];
  logic [31:0]   exp_ucnt;

  vga_pixel_fifo #(.DEPTH(DEPTH), .PIXEL_WIDTH(PW)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .write_valid       (write_valid),
    .write_ready       (write_ready),
    .write_pixel       (write_pixel),
    .write_frame_start (write_frame_start),
    .frame_begin       (frame_begin),
    .read_enable       (read_enable),
    .read_pixel        (read_pixel),
    .underflow         (underflow),
    .resync            (resync),
    .level             (level),
    .underflow_count   (underflow_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, read_pixel);
    end else begin
      e = 32'(exp_q.pop_front());
      check(tag, 32'(read_pixel), e);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix"},   32'(read_pixel),      32'd0);
    check({tag, "_uf"},    32'(underflow),       32'd0);
    check({tag, "_rs"},    32'(resync),          32'd0);
    check({tag, "_lvl"},   32'(level),           32'd0);
    check({tag, "_wrdy"},  32'(write_ready),     32'd1);
    check({tag, "_ucnt"},  32'(underflow_count), 32'd0);
  endtask

  task automatic push_px(input logic [PW-1:0] p, input logic tag, input bit track);
    write_valid       = 1'b1;
    write_pixel       = p;
    write_frame_start = tag;
    if (track) exp_q.push_back(p);
    tick();
    write_valid       = 1'b0;
    write_frame_start = 1'b0;
  endtask

  initial begin
`ifdef VGA_PIXEL_FIFO_STATS_EN
    exp_ucnt = 32'd1;
`else
    exp_ucnt = 32'd0;
`endif
    // Reset values
    tick();
    tick();
    check_reset("rst");
    reset_n = 1'b1;

    // Tagged frame of 8 pixels streamed out in order
    push_px(3'd1, 1'b1, 1'b1);
    for (int v = 2; v <= 7; v++) push_px(PW'(v), 1'b0, 1'b1);
    push_px(3'd1, 1'b0, 1'b1);
    check("t1_level_full8", 32'(level), 32'd8);
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    read_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_pop("t1_pix");
    end
    read_enable = 1'b0;
    check("t1_level_end", 32'(level), 32'd0);

    // Underflow after two pixels drops back to SEEK
    push_px(3'd3, 1'b0, 1'b1);
    push_px(3'd5, 1'b0, 1'b1);
    read_enable = 1'b1;
    tick();
    check_pop("t4_pix0");
    tick();
    check_pop("t4_pix1");
    tick();
    check("t4_pix_black", 32'(read_pixel), 32'd0);
    check("t4_uf_pulse", 32'(underflow), 32'd1);
    read_enable = 1'b0;
    tick();
    check("t4_uf_low", 32'(underflow), 32'd0);
    check("t4_ucnt", 32'(underflow_count), exp_ucnt);
    push_px(3'd2, 1'b0, 1'b0);
    check("t4_seek_lvl1", 32'(level), 32'd1);
    tick();
    check("t4_seek_discard", 32'(level), 32'd0);

    // SEEK discards untagged pixels, parks on tagged head in ARMED
    push_px(3'd2, 1'b0, 1'b0);
    push_px(3'd3, 1'b0, 1'b0);
    push_px(3'd4, 1'b0, 1'b0);
    push_px(3'd6, 1'b1, 1'b1);
    check("t2_level_after_seek", 32'(level), 32'd1);
    tick();
    check("t2_level_armed", 32'(level), 32'd1);
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    check("t2_armed_pix", 32'(read_pixel), 32'd0);
    check("t2_armed_lvl", 32'(level), 32'd1);

    // Fill to DEPTH with write_valid held high
    write_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!write_ready) break;
      write_pixel = PW'(i % 7 + 1);
      exp_q.push_back(write_pixel);
      tick();
    end
    check("t3_level_full", 32'(level), 32'd16);
    check("t3_wrdy_full", 32'(write_ready), 32'd0);
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    check("t3_level_hold", 32'(level), 32'd16);
    read_enable = 1'b1;
    tick();
    check_pop("t3_pop_full");
    check("t3_level_pop_nopush", 32'(level), 32'd15);
    read_enable = 1'b0;
    write_valid = 1'b0;
    tick();
    check("t3_wrdy_back", 32'(write_ready), 32'd1);
    check("t3_level_15", 32'(level), 32'd15);

    // frame_begin with untagged head forces resync and a one-per-clock flush
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    check("t5_resync_pulse", 32'(resync), 32'd1);
    check("t5_resync_pix", 32'(read_pixel), 32'd0);
    tick();
    check("t5_resync_low", 32'(resync), 32'd0);
    check("t5_flush_14", 32'(level), 32'd14);
    repeat (13) tick();
    check("t5_flush_1", 32'(level), 32'd1);
    tick();
    check("t5_flush_0", 32'(level), 32'd0);
    exp_q.delete();

    // Aligned frame_begin (head tagged after concurrent pop) keeps streaming
    push_px(3'd3, 1'b1, 1'b1);
    push_px(3'd4, 1'b0, 1'b1);
    push_px(3'd5, 1'b1, 1'b1);
    push_px(3'd6, 1'b0, 1'b1);
    push_px(3'd7, 1'b0, 1'b1);
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    read_enable = 1'b1;
    tick();
    check_pop("t5b_pix3");
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    check("t5b_no_resync", 32'(resync), 32'd0);
    check_pop("t5b_pix4");
    tick();
    check_pop("t5b_pix5");
    read_enable = 1'b0;
    check("t5b_level", 32'(level), 32'd2);

    // Asynchronous reset mid-stream at level 9
    for (int k = 0; k < 7; k++) push_px(PW'(k + 1), 1'b0, 1'b0);
    check("t6_level9", 32'(level), 32'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("t6_async");
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_level_rel", 32'(level), 32'd0);
    check("t6_wrdy_rel", 32'(write_ready), 32'd1);
    push_px(3'd4, 1'b0, 1'b0);
    check("t6_seek_lvl1", 32'(level), 32'd1);
    tick();
    check("t6_seek_discard", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fifo.md
# vga_pixel_fifo

Elastic pixel buffer that sits directly upstream of the VGA scan-out stage. A pixel producer (pattern generator or framebuffer reader) pushes 3-bit RGB pixels at its own pace. The scan-out stage pops one pixel per visible-area clock. The block aligns producer frames to scan-out frames with a start-of-frame tag, and substitutes black while reporting the event whenever the buffer runs dry.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- PIXEL_WIDTH, 3, bits per pixel (R,G,B order, MSB = red)
- clock  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- write_valid  in  1  producer has a pixel on write_pixel
- write_ready  out  1  FIFO can accept; equals !full
- write_pixel  in  PIXEL_WIDTH  pixel data
- write_frame_start  in  1  tags this pixel as first pixel of a frame
- frame_begin  in  1  one-cycle pulse from scan-out, one clock before first visible pixel
- read_enable  in  1  scan-out consumes a pixel this cycle (visible area)
- read_pixel  out  PIXEL_WIDTH  registered pixel to scan-out
- underflow  out  1  one-cycle pulse: read_enable while STREAM and empty
- resync  out  1  one-cycle pulse: frame_begin while STREAM and head not tagged
- level  out  $clog2(DEPTH+1)  current occupancy
- underflow_count  out  16  saturating underflow counter (see Configuration)

## Operation
- Storage: DEPTH entries of {tag, pixel}; write/read pointers wrap modulo DEPTH; level is an explicit counter.
- Push occurs when write_valid && write_ready. write_ready depends only on the current level and does not see a same-cycle pop; a full FIFO refuses a push even if a pop happens that cycle.
- FSM states:
  - SEEK (reset state): while not empty and the head is untagged, discard one head entry per cycle. On reaching a tagged head, go to ARMED. read_pixel = 0.
  - ARMED: hold; read_enable is ignored and read_pixel = 0. On frame_begin, go to STREAM.
  - STREAM: read_enable && !empty pops the head, and read_pixel ← head pixel. read_enable && empty sets read_pixel ← 0, pulses underflow, and goes to SEEK.
- frame_begin in STREAM:
  - If the head is tagged, stay in STREAM (aligned).
  - Otherwise pulse resync and go to SEEK.
  - frame_begin in SEEK is ignored.
- Simultaneous frame_begin and read_enable in STREAM: read_enable is processed first (pop or underflow). The tag check applies to the head after that pop.
- Push and pop in the same cycle leave level unchanged. Pointer wrap from DEPTH-1 goes to 0.

## Timing
- Reset (async assert, sync release): pointers 0, level 0, state SEEK, read_pixel 0, underflow 0, resync 0, underflow_count 0, write_ready 1.
- Pop latency: read_pixel is valid the cycle after read_enable is sampled. It holds that value until the next read_enable, or until it is forced to 0 on leaving STREAM.
- Write-to-read: a pushed entry is poppable the next cycle (no fall-through).
- SEEK discards at most one entry per clock.
- An ARMED→STREAM transition on frame_begin at edge N makes a pop possible at edge N+1.
- underflow and resync are high for exactly one cycle per event.
- reset_n asserted mid-frame returns the block to SEEK immediately. Buffered data is lost, and the producer must restart at a tagged pixel.

## Configuration
- VGA_PIXEL_FIFO_STATS_EN defined: underflow_count increments on each underflow pulse, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: the counter logic is not built and underflow_count is tied to 0. The underflow pulse is unaffected.

## Test plan
- Reset, push 8 pixels with tag on the first (values 1..7,1), frame_begin, read_enable ×8: read_pixel = 1,2,3,4,5,6,7,1 on consecutive cycles, each one cycle after its read_enable; level ends at 0.
- Push 3 untagged pixels then 1 tagged pixel: SEEK discards 3 in 3 cycles, level = 1, state ARMED; read_enable before frame_begin leaves read_pixel = 0.
- Fill to 16 with write_valid held high: write_ready = 0 at level 16. A pop plus attempted push in the same cycle gives level 15 and no push accepted.
- STREAM with 2 entries, read_enable ×3: pixels appear on cycles 1–2, third read gives read_pixel = 0 with underflow pulsed once, and state SEEK. With the macro defined, underflow_count = 1; without it, underflow_count stays 0.
- STREAM with an untagged head and frame_begin: resync pulses once and the FSM returns to SEEK. With a tagged head, there is no pulse and streaming continues.
- Assert reset_n low mid-stream with level 9: all outputs return to their reset values asynchronously, and level reads 0 after release.
